// File: rtl/imm_instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, opcodes,
// the field bundle carried through the pipeline and the bit-scatter packing function.
package imm_instr_encoder_pkg;

  // Same codes the decoder's format select uses; 3'b110 and 3'b111 are illegal.
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_U = 3'b001,
    FMT_J = 3'b010,
    FMT_S = 3'b011,
    FMT_B = 3'b100,
    FMT_R = 3'b101
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // Out-of-range immediates are still packed from their truncated bits.
  function automatic logic [31:0] pack_instr(fields_t f);
    logic [31:0] w;
    w = '0;
    case (f.fmt)
      FMT_I: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                  f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: w = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      FMT_R: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_instr_encoder_if.sv
// Handshake and data bundle for imm_instr_encoder; slave = encoder, master = producer/consumer.
// err_cnt exists only when IMM_ENC_ERR_CNT_EN is defined.
interface imm_instr_encoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             range_err;
  logic [CNT_W-1:0] instr_cnt;
`ifdef IMM_ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  modport master (
`ifdef IMM_ENC_ERR_CNT_EN
    input  err_cnt,
`endif
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, range_err, instr_cnt
  );

  modport slave (
`ifdef IMM_ENC_ERR_CNT_EN
    output err_cnt,
`endif
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, range_err, instr_cnt
  );
endinterface

// File: rtl/imm_instr_encoder_range_check.sv
// imm_range_check: flags immediates that the selected format cannot represent.
// Purely combinational; illegal format codes always flag.
module imm_range_check
  import imm_instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);

  // A field fits when every bit above its sign bit replicates the sign.
  always_comb begin
    // NOTE: err gets a value on every path (default first), so no latch is inferred.
    err = 1'b1;
    case (fmt)
      FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      FMT_J:        err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      FMT_U:        err = |imm[11:0];
      FMT_R:        err = 1'b0;
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder: 2-stage valid/ready pipeline packing RV32I fields + immediate into a word.
// Optional feature macro IMM_ENC_ERR_CNT_EN adds a saturating err_cnt output.
module imm_instr_encoder
  import imm_instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  imm_instr_encoder_if.slave bus
);

  fields_t          in_fields;
  logic             in_err;
  logic             s2_load;
  logic             in_ready;
  logic             out_fire;

  logic             s1_valid_q, s1_valid_d;
  fields_t          s1_fields_q, s1_fields_d;
  logic             s1_err_q, s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  imm_range_check u_range_check (
    .fmt (bus.fmt),
    .imm (bus.imm),
    .err (in_err)
  );

  always_comb begin
    in_fields = '{fmt: bus.fmt, opcode: bus.opcode, rd: bus.rd, rs1: bus.rs1,
                  rs2: bus.rs2, funct3: bus.funct3, funct7: bus.funct7, imm: bus.imm};

    // Stage 2 frees up whenever it is empty or being drained; stage 1 follows it.
    s2_load  = !s2_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_load;
    out_fire = s2_valid_q && bus.out_ready;

    s1_valid_d  = s1_valid_q;
    s1_fields_d = s1_fields_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    instr_cnt_d = instr_cnt_q;

    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_fields_d = in_fields;
        s1_err_d    = in_err;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = pack_instr(s1_fields_q);
        err_d   = s1_err_q;
      end
    end

    if (out_fire) instr_cnt_d = instr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_fields_q <= s1_fields_d;
    s1_err_q    <= s1_err_d;
  end

`ifdef IMM_ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_fire && err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.instr     = instr_q;
  assign bus.range_err = err_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed vectors, stall/reset scenarios and
// randomized traffic scored against an arithmetic model plus an immediate decoder round-trip.
module tb_imm_instr_encoder;
  import imm_instr_encoder_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_instr_encoder_if #(.CNT_W(CNT_W)) bus ();

  imm_instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_cnt = 0;
`ifdef IMM_ENC_ERR_CNT_EN
  int unsigned exp_err_cnt = 0;
`endif
  logic        s_in_ready, s_out_valid, s_err, s_acc;
  logic [31:0] s_instr, s_cnt;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_instr;
  logic        hold_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference packing from the format bit-position tables, using plain shifts and masks.
  function automatic logic [31:0] model_pack(fields_t f);
    int unsigned imm = f.imm, op = 32'(f.opcode), rd = 32'(f.rd), r1 = 32'(f.rs1);
    int unsigned r2 = 32'(f.rs2), f3 = 32'(f.funct3), f7 = 32'(f.funct7);
    case (f.fmt)
      FMT_I: return ((imm & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      FMT_S: return (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
      FMT_B: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20)
                    | (r1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | op;
      FMT_U: return (imm & 32'hFFFFF000) | (rd << 7) | op;
      FMT_J: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      FMT_R: return (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  // Representability expressed as signed numeric ranges and alignment.
  function automatic logic model_err(logic [2:0] fmt, logic [31:0] imm);
    longint s = longint'($signed(imm));
    case (fmt)
      FMT_I, FMT_S: return (s < -2048) || (s > 2047);
      FMT_B:        return ((imm & 1) != 0) || (s < -4096) || (s > 4095);
      FMT_J:        return ((imm & 1) != 0) || (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1);
      FMT_U:        return (imm & 32'hFFF) != 0;
      FMT_R:        return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

  // Immediate decoder as the core would apply it to a packed word.
  function automatic logic [31:0] model_decode(logic [2:0] fmt, logic [31:0] w);
    int unsigned v;
    case (fmt)
      FMT_I: begin v = w >> 20; if ((v & 32'h800) != 0) v |= 32'hFFFFF000; end
      FMT_S: begin
        v = ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
        if ((v & 32'h800) != 0) v |= 32'hFFFFF000;
      end
      FMT_B: begin
        v = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5)
            | (((w >> 8) & 32'hF) << 1);
        if ((v & 32'h1000) != 0) v |= 32'hFFFFE000;
      end
      FMT_J: begin
        v = (((w >> 31) & 1) << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 1) << 11)
            | (((w >> 21) & 32'h3FF) << 1);
        if ((v & 32'h100000) != 0) v |= 32'hFFE00000;
      end
      FMT_U:   v = w & 32'hFFFFF000;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic fields_t rand_fields();
    fields_t     f;
    int unsigned sel = $urandom_range(0, 15);
    logic [31:0] r = $urandom;
    f.fmt    = (sel < 14) ? 3'(sel % 6) : 3'(sel - 8);
    f.opcode = 7'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom);
    f.rs2    = 5'($urandom); f.funct3 = 3'($urandom); f.funct7 = 7'($urandom);
    if ($urandom_range(0, 7) == 0) f.imm = r;
    else case (f.fmt)
      FMT_I, FMT_S: f.imm = {{20{r[11]}}, r[11:0]};
      FMT_B:        f.imm = {{19{r[12]}}, r[12:1], 1'b0};
      FMT_J:        f.imm = {{11{r[20]}}, r[20:1], 1'b0};
      FMT_U:        f.imm = {r[31:12], 12'h000};
      default:      f.imm = r;
    endcase
    return f;
  endfunction

  function automatic fields_t mk(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                                 logic [6:0] f7, logic [31:0] imm);
    return '{fmt: fmt, opcode: op, rd: rd, rs1: rs1, rs2: rs2, funct3: f3, funct7: f7, imm: imm};
  endfunction

  // One clock: drive on the falling edge, sample 1 time unit later, score the coming edge.
  task automatic step(input logic iv, input fields_t f, input logic ordy);
    int unsigned pending;
    exp_t        e;
    @(negedge clk);
    bus.in_valid = iv; bus.fmt = f.fmt; bus.opcode = f.opcode; bus.rd = f.rd;
    bus.rs1 = f.rs1; bus.rs2 = f.rs2; bus.funct3 = f.funct3; bus.funct7 = f.funct7;
    bus.imm = f.imm; bus.out_ready = ordy;
    #1;
    s_in_ready = bus.in_ready; s_out_valid = bus.out_valid;
    s_instr = bus.instr; s_err = bus.range_err; s_cnt = 32'(bus.instr_cnt);
    check("instr_cnt", s_cnt, 32'(exp_cnt % (1 << CNT_W)));
`ifdef IMM_ENC_ERR_CNT_EN
    check("err_cnt", 32'(bus.err_cnt), 32'(exp_err_cnt));
`endif
    if (hold_pend) begin
      check("hold_valid", 32'(s_out_valid), 1);
      check("hold_instr", s_instr, hold_instr);
      check("hold_err", 32'(s_err), 32'(hold_err));
    end
    hold_pend = s_out_valid && !ordy;
    hold_instr = s_instr; hold_err = s_err;
    if (s_out_valid && ordy) begin
      pending = sb.size();
      check("out_has_pending", 32'(pending != 0), 1);
      if (pending != 0) begin
        e = sb.pop_front();
        check("instr", s_instr, e.instr);
        check("range_err", 32'(s_err), 32'(e.err));
        if (!e.err && e.fmt != FMT_R) check("roundtrip_imm", model_decode(e.fmt, s_instr), e.imm);
        exp_cnt++;
`ifdef IMM_ENC_ERR_CNT_EN
        if (e.err && exp_err_cnt != (1 << CNT_W) - 1) exp_err_cnt++;
`endif
      end
    end
    s_acc = iv && s_in_ready;
    if (s_acc) sb.push_back('{instr: model_pack(f), err: model_err(f.fmt, f.imm),
                              imm: f.imm, fmt: f.fmt});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_instr", bus.instr, 0);
    check("rst_range_err", 32'(bus.range_err), 0);
    check("rst_instr_cnt", 32'(bus.instr_cnt), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    sb.delete(); exp_cnt = 0; hold_pend = 1'b0;
`ifdef IMM_ENC_ERR_CNT_EN
    check("rst_err_cnt", 32'(bus.err_cnt), 0);
    exp_err_cnt = 0;
`endif
  endtask

  // Accept one word with downstream open and verify the two-cycle latency and the result.
  task automatic send_directed(input string tag, input fields_t f,
                               input logic [31:0] want, input logic want_err);
    fields_t idle = f;
    step(1'b1, f, 1'b1);
    check({tag, "_accept"}, 32'(s_acc), 1);
    step(1'b0, idle, 1'b1);
    check({tag, "_lat1"}, 32'(s_out_valid), 0);
    step(1'b0, idle, 1'b1);
    check({tag, "_lat2"}, 32'(s_out_valid), 1);
    check({tag, "_word"}, s_instr, want);
    check({tag, "_err"}, 32'(s_err), 32'(want_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fields_t items[4];
    fields_t cur;
    int      idx, cyc, n_sent;
    logic    have_cur;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
    do_reset(2);

    send_directed("I_neg1", mk(FMT_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'hFFFFFFFF), 32'hFFF00093, 0);
    send_directed("B_8",    mk(FMT_B, OPC_BRANCH, 0, 1, 2, 0, 0, 32'd8), 32'h00208463, 0);
    send_directed("B_9",    mk(FMT_B, OPC_BRANCH, 0, 1, 2, 0, 0, 32'd9), 32'h00208463, 1);
    send_directed("J_800",  mk(FMT_J, OPC_JAL, 1, 0, 0, 0, 0, 32'h800), 32'h001000EF, 0);
    send_directed("I_800",  mk(FMT_I, OPC_OP_IMM, 1, 0, 0, 0, 0, 32'h800), 32'h80000093, 1);
    send_directed("U_odd",  mk(FMT_U, OPC_LUI, 5, 0, 0, 0, 0, 32'h12345001), 32'h123452B7, 1);
    send_directed("S_m4",   mk(FMT_S, OPC_STORE, 0, 2, 5, 2, 0, 32'hFFFFFFFC), 32'hFE512E23, 0);
    send_directed("R_sub",  mk(FMT_R, OPC_OP, 1, 2, 3, 0, 7'h20, 32'hDEADBEEF), 32'h403100B3, 0);
    send_directed("illeg",  mk(3'b110, OPC_OP, 1, 2, 3, 0, 0, 32'h0), 32'h00000000, 1);

    // Two words in flight with downstream blocked, then reset: both must vanish.
    step(1'b1, rand_fields(), 1'b0);
    step(1'b1, rand_fields(), 1'b0);
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, rand_fields(), 1'b1);
      check("post_rst_quiet", 32'(s_out_valid), 0);
    end

    // Backpressure: 5 blocked cycles take only two words, then everything drains in order.
    do_reset(1);
    for (int i = 0; i < 4; i++) items[i] = rand_fields();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, items[idx], 1'b0);
      if (s_acc) idx++;
    end
    check("stall_accepted", 32'(idx), 2);
    check("stall_in_ready", 32'(s_in_ready), 0);
    cyc = 0;
    while ((idx < 4 || sb.size() != 0) && cyc < 50) begin
      step(idx < 4, items[idx % 4], 1'b1);
      if (s_acc) idx++;
      cyc++;
    end
    check("stall_drain_in_time", 32'(cyc < 50), 1);
    step(1'b0, items[0], 1'b1);
    check("stall_instr_cnt", s_cnt, 4);

    // Randomized traffic with random input gaps and output stalls.
    do_reset(1);
    n_sent = 0; cyc = 0; have_cur = 1'b0;
    while ((n_sent < 1200 || sb.size() != 0) && cyc < 20000) begin
      if (!have_cur) begin cur = rand_fields(); have_cur = 1'b1; end
      step((n_sent < 1200) && ($urandom_range(0, 3) != 0), cur, $urandom_range(0, 3) != 0);
      if (s_acc) begin n_sent++; have_cur = 1'b0; end
      cyc++;
    end
    check("random_drain_in_time", 32'(cyc < 20000), 1);
    check("random_sent", 32'(n_sent), 1200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
